// File: rtl/mux_scan_nto1.sv
// Registered N_CH:1 multiplexer with manual select and one-shot channel scan, valid/ready output.
// Optional scan channel mask: define MUX_SCAN_MASK_EN to add the ch_mask input.
module mux_scan_nto1 #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned DW    = 1,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 start,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]      ch_mask,
`endif
  output logic [DW-1:0]        out_data,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    rem_q, rem_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               slot_free;
  logic               accept;
  logic [SEL_W-1:0]   man_ch;
  logic [SEL_W-1:0]   scan_ch;
  logic [N_CH-1:0]    start_rem;

  // Channel data selector; indices outside the channel range are never generated.
  function automatic logic [DW-1:0] pick_ch(input logic [N_CH*DW-1:0] d,
                                            input logic [SEL_W-1:0]   idx);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = d[k*DW +: DW];
    end
    return r;
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = out_valid_q && out_ready;
  assign man_ch    = ({1'b0, sel} < (SEL_W+1)'(N_CH)) ? sel : '0;

`ifdef MUX_SCAN_MASK_EN
  assign start_rem = ch_mask;
`else
  assign start_rem = '1;
`endif

  // The scan counter is the lowest channel still pending in the sweep.
  always_comb begin
    scan_ch = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (rem_q[k]) scan_ch = SEL_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!mode) begin
          if (slot_free) begin
            out_data_d  = pick_ch(din, man_ch);
            out_ch_d    = man_ch;
            out_valid_d = 1'b1;
          end
        end else begin
          if (slot_free) out_valid_d = 1'b0;
          if (start) begin
            rem_d   = start_rem;
            state_d = (start_rem == '0) ? ST_DONE : ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (rem_q != '0) begin
          if (slot_free) begin
            out_data_d  = pick_ch(din, scan_ch);
            out_ch_d    = scan_ch;
            out_valid_d = 1'b1;
            rem_d       = rem_q & (rem_q - N_CH'(1));
          end
        end else if (accept) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The DONE cycle never presents a sample, including an empty masked sweep.
    if (state_d == ST_DONE) out_valid_d = 1'b0;

    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
